// File: rtl/riscv_trace_pkg.sv
// riscv_trace_pkg: shared trace entry layout and kind bit positions.
// The ts field exists only when RISCV_TRACE_TIMESTAMP_EN is defined.
package riscv_trace_pkg;
   localparam int TRACE_DATA_W = 32;
   localparam int TRACE_ADDR_W = 9;
   localparam int TRACE_CNT_W  = 16;
   localparam int KIND_REG = 0;
   localparam int KIND_MEM = 1;
   localparam int KIND_WR  = 2;
   typedef struct packed {
      logic [2:0]              kind;
      logic [4:0]              reg_num;
      logic [TRACE_DATA_W-1:0] reg_data;
      logic [TRACE_ADDR_W-1:0] addr;
      logic [TRACE_DATA_W-1:0] mem_data;
`ifdef RISCV_TRACE_TIMESTAMP_EN
      logic [TRACE_CNT_W-1:0]  ts;
`endif
   } trace_entry_t;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: show-ahead synchronous FIFO; dout reads 0 while empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module trace_fifo #(
   parameter  int W     = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   level_q, level_d;
   logic          do_push, do_pop;
   assign empty   = level_q == '0;
   assign full    = level_q == (AW+1)'(DEPTH);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign level   = level_q;
   assign dout    = empty ? '0 : mem_q[rd_q];
   always_comb begin
      level_d = do_push && !do_pop ? level_q + 1'b1 :
                !do_push && do_pop ? level_q - 1'b1 : level_q;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         level_q <= level_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end
endmodule

// File: rtl/riscv_trace_buffer.sv
// riscv_trace_buffer: packs core writeback/memory events into a drop-on-overflow trace FIFO.
// Define RISCV_TRACE_TIMESTAMP_EN to stamp entries with a free-running cycle counter.
module riscv_trace_buffer
   import riscv_trace_pkg::*;
#(
   parameter int DATA_W = TRACE_DATA_W,
   parameter int ADDR_W = TRACE_ADDR_W,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = TRACE_CNT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     capture_en,
   input  logic                     reg_write_sig,
   input  logic [4:0]               reg_num,
   input  logic [DATA_W-1:0]        reg_data,
   input  logic                     wr,
   input  logic                     rd,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [DATA_W-1:0]        rd_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2:0]               out_kind,
   output logic [4:0]               out_reg_num,
   output logic [DATA_W-1:0]        out_reg_data,
   output logic [ADDR_W-1:0]        out_addr,
   output logic [DATA_W-1:0]        out_mem_data,
   output logic [CNT_W-1:0]         out_ts,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [CNT_W-1:0]         drop_count
);
   trace_entry_t din, dout;
   logic reg_ev, mem_ev, push, pop, full, empty, drop;
   logic             overflow_q;
   logic [CNT_W-1:0] drop_q, drop_d;
   assign reg_ev    = reg_write_sig && reg_num != 5'd0;
   assign mem_ev    = wr || rd;
   assign push      = capture_en && (reg_ev || mem_ev);
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign drop      = push && full && !pop;
   assign drop_d    = drop && drop_q != '1 ? drop_q + 1'b1 : drop_q;
`ifdef RISCV_TRACE_TIMESTAMP_EN
   logic [CNT_W-1:0] ts_q;
   always_ff @(posedge clk) ts_q <= !reset ? '0 : ts_q + 1'b1;
   assign out_ts = dout.ts;
`else
   assign out_ts = '0;
`endif
   // Absent halves of an entry are zeroed; a simultaneous wr/rd counts as a store.
   always_comb begin
      din                = '0;
      din.kind[KIND_REG] = reg_ev;
      din.kind[KIND_MEM] = mem_ev;
      din.kind[KIND_WR]  = wr;
      din.reg_num        = reg_ev ? reg_num : '0;
      din.reg_data       = reg_ev ? reg_data : '0;
      din.addr           = mem_ev ? addr : '0;
      din.mem_data       = wr ? wr_data : rd ? rd_data : '0;
`ifdef RISCV_TRACE_TIMESTAMP_EN
      din.ts             = ts_q;
`endif
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         overflow_q <= overflow_q || drop;
         drop_q     <= drop_d;
      end
   end
   assign overflow     = overflow_q;
   assign drop_count   = drop_q;
   assign out_kind     = dout.kind;
   assign out_reg_num  = dout.reg_num;
   assign out_reg_data = dout.reg_data;
   assign out_addr     = dout.addr;
   assign out_mem_data = dout.mem_data;
   trace_fifo #(.W($bits(trace_entry_t)), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .dout  (dout),
      .full  (full),
      .empty (empty),
      .level (level)
   );
endmodule

// File: doc/riscv_trace_buffer.md
Name: riscv_trace_buffer

Overview:
- Downstream observer of the core's commit/debug outputs: register writeback and data-memory access.
- Each cycle with a qualifying event, packs one trace entry into an internal FIFO.
- Drains the FIFO over a valid/ready stream to a host/testbench sink.
- Sits beside the core at the top level; it never back-pressures the core, so overflow drops entries and counts them.

Parameters:
- DATA_W, 32, width of reg_data, wr_data, rd_data and the entry data fields.
- ADDR_W, 9, width of the memory address field.
- DEPTH, 16, FIFO entries; must be a power of two and ≥2.
- CNT_W, 16, width of drop_count and the timestamp.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- capture_en  in  1  1 = record events; 0 = ignore inputs, draining continues
- reg_write_sig  in  1  core register-write strobe
- reg_num  in  5  destination register
- reg_data  in  DATA_W  writeback value
- wr  in  1  data-memory write strobe
- rd  in  1  data-memory read strobe
- addr  in  ADDR_W  data-memory address
- wr_data  in  DATA_W  store data
- rd_data  in  DATA_W  load data
- out_valid  out  1  head entry valid
- out_ready  in  1  sink accepts head
- out_kind  out  3  {mem_is_write, mem_valid, reg_valid}
- out_reg_num  out  5  entry register number
- out_reg_data  out  DATA_W  entry register value
- out_addr  out  ADDR_W  entry memory address
- out_mem_data  out  DATA_W  entry memory data
- out_ts  out  CNT_W  entry timestamp (optional feature)
- level  out  $clog2(DEPTH)+1  occupied entries
- overflow  out  1  sticky: an event was dropped
- drop_count  out  CNT_W  saturating count of dropped events

Behaviour:
- Reset (reset==0 at a clk edge): pointers, level, overflow, drop_count and timestamp cleared. out_valid=0; all out_* fields read 0 while empty. Reset mid-drain discards all contents.
- reg event: reg_write_sig && reg_num!=0 (x0 writes are not traced).
- mem event: wr || rd. If both are asserted, it is treated as a write.
- push: capture_en && (reg event || mem event). Exactly one entry per cycle.
  - kind[0]=reg event; kind[1]=mem event; kind[2]=wr.
  - Fields of an absent event are written as 0.
  - out_mem_data = wr ? wr_data : rd_data.
- FIFO is show-ahead: out_* driven combinationally from the head slot; out_valid = level!=0.
- pop = out_valid && out_ready.
- Latency: an event sampled at edge N is visible with out_valid=1 after edge N, if the FIFO was empty.
- Full with push and no pop: entry dropped, overflow<=1, drop_count increments and saturates at all-ones.
- Full with push and pop in the same cycle: both occur, no drop, level unchanged.
- Empty with push and pop: no pop (out_valid=0), push accepted.
- Pointers are ADDR=$clog2(DEPTH) bits and wrap naturally. level is updated +1 / −1 / 0.
- overflow and drop_count clear only on reset.
- out_* fields must stay stable while out_valid && !out_ready.

Optional Feature:
- RISCV_TRACE_TIMESTAMP_EN defined:
  - Free-running CNT_W cycle counter, cleared at reset, wrapping.
  - Its value at the push edge is stored in the entry and presented on out_ts.
- Not defined: no counter and no storage for it; out_ts tied to 0.

Decomposition:
- Package riscv_trace_pkg:
  - trace_entry_t packed struct (kind, reg_num, reg_data, addr, mem_data, ts).
  - Localparams KIND_REG=0, KIND_MEM=1, KIND_WR=2.
- Sub-module trace_fifo:
  - Generic show-ahead synchronous FIFO parameterised on entry type/width and DEPTH.
  - Ports: push, pop, din, dout, full, empty, level.
- riscv_trace_buffer holds event qualification, entry packing, drop accounting and the timestamp.

Test Plan:
- Reset, then reg_write_sig=1, reg_num=5, reg_data=0x1234, out_ready=0 → next cycle out_valid=1, out_kind=3'b001, out_reg_num=5, out_reg_data=0x1234, level=1.
- Load cycle: rd=1, addr=0x1F0, rd_data=0xDEADBEEF, reg_write_sig=1, reg_num=7, reg_data=0xDEADBEEF → one entry, out_kind=3'b011, out_addr=0x1F0, out_mem_data=0xDEADBEEF.
- reg_write_sig=1 with reg_num=0, and separately capture_en=0 with wr=1 → no entries, level stays 0.
- out_ready=0, 20 consecutive store events (wr=1, addr=i), DEPTH=16 → level=16, overflow=1, drop_count=4. Then out_ready=1 drains addr 0..15 in order; out_valid=0 after 16 pops.
- Full FIFO, push and out_ready=1 in the same cycle → drop_count unchanged, level stays 16, new entry appears last.
- With RISCV_TRACE_TIMESTAMP_EN defined: events at cycles 3 and 10 after reset release → out_ts=3 then 10. Without the macro, out_ts=0. Also assert reset mid-drain → out_valid=0 next cycle and level=0.
